byte_perm_pipe: RTL and testbench

//  Parametrised, multi-round lane-permutation pipeline for the pipelined crypt datapath.

---
 rtl/crypt_perm_pkg.sv | 33 +++
 rtl/byte_perm_stage.sv | 61 ++++++
 rtl/byte_perm_pipe.sv | 79 +++++++
 tb/tb_byte_perm_pipe.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/crypt_perm_pkg.sv
// Shared types and helpers for the byte_perm_pipe lane-permutation datapath.
package crypt_perm_pkg;

    localparam int BLK_CNT_W = 16;
    localparam int PERM_W    = 2;

    typedef enum logic [1:0] {
        SEL_SWAP_PAIRS = 2'b00,
        SEL_X12        = 2'b01,
        SEL_X03        = 2'b10,
        SEL_X13        = 2'b11
    } perm_sel_e;

    // Permutes four PERM_W-bit lanes; the stage feeds it lane indices so the
    // resulting map can be applied to lanes of any width.
    function automatic logic [4*PERM_W-1:0] perm4(input logic [4*PERM_W-1:0] d,
                                                  input perm_sel_e sel);
        logic [PERM_W-1:0] l0, l1, l2, l3;
        logic [4*PERM_W-1:0] o;
        l0 = d[0*PERM_W +: PERM_W];
        l1 = d[1*PERM_W +: PERM_W];
        l2 = d[2*PERM_W +: PERM_W];
        l3 = d[3*PERM_W +: PERM_W];
        case (sel)
            SEL_SWAP_PAIRS: o = {l2, l3, l0, l1};
            SEL_X03:        o = {l0, l2, l1, l3};
            SEL_X12:        o = {l3, l1, l2, l0};
            default:        o = {l1, l2, l3, l0};
        endcase
        return o;
    endfunction

endpackage

// File: rtl/byte_perm_stage.sv
// One registered permutation round with valid/ready; the round index picks
// which key slice applies for encrypt and for decrypt.
module byte_perm_stage
    import crypt_perm_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int ROUND  = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*WIDTH-1:0]   in_data,
    input  logic [2*STAGES-1:0]      in_key,
    input  logic                     in_decrypt,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*WIDTH-1:0]   out_data,
    output logic [2*STAGES-1:0]      out_key,
    output logic                     out_decrypt
);

    localparam logic [4*PERM_W-1:0] IDENT = {2'd3, 2'd2, 2'd1, 2'd0};

    perm_sel_e              sel;
    logic [4*PERM_W-1:0]    map;
    logic [LANES*WIDTH-1:0] perm_data;

    // Decrypt walks the key slices in reverse so it undoes the encrypt order.
    always_comb begin
        sel = perm_sel_e'(in_decrypt ? in_key[2*(STAGES-1-ROUND) +: 2]
                                     : in_key[2*ROUND +: 2]);
        map = perm4(IDENT, sel);
        perm_data = '0;
        for (int g = 0; g < LANES/4; g++) begin
            for (int j = 0; j < 4; j++) begin
                perm_data[(4*g+j)*WIDTH +: WIDTH] =
                    in_data[(4*g + int'(map[PERM_W*j +: PERM_W]))*WIDTH +: WIDTH];
            end
        end
    end

    assign in_ready = ~out_valid | out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_key     <= '0;
            out_decrypt <= 1'b0;
        end else if (in_ready) begin
            out_valid   <= in_valid;
            out_data    <= perm_data;
            out_key     <= in_key;
            out_decrypt <= in_decrypt;
        end
    end

endmodule

// File: rtl/byte_perm_pipe.sv
// Multi-round lane-permutation pipeline with valid/ready flow control.
// Optional feature: define BLK_CNT_EN to add the 16-bit blk_cnt handshake counter.
module byte_perm_pipe
    import crypt_perm_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*WIDTH-1:0]   in_data,
    input  logic [2*STAGES-1:0]      in_key,
    input  logic                     in_decrypt,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*WIDTH-1:0]   out_data
`ifdef BLK_CNT_EN
    ,
    output logic [BLK_CNT_W-1:0]     blk_cnt
`endif
);

    logic [STAGES:0]                  vld;
    logic [STAGES:0]                  rdy;
    logic [STAGES:0]                  dec;
    logic [STAGES:0][LANES*WIDTH-1:0] data;
    logic [STAGES:0][2*STAGES-1:0]    key;

    assign vld[0]      = in_valid;
    assign data[0]     = in_data;
    assign key[0]      = in_key;
    assign dec[0]      = in_decrypt;
    assign rdy[STAGES] = out_ready;

    // Key and mode ride along with each beat so every round sees the values
    // captured at acceptance.
    for (genvar s = 0; s < STAGES; s++) begin : g_round
        byte_perm_stage #(
            .LANES  (LANES),
            .WIDTH  (WIDTH),
            .STAGES (STAGES),
            .ROUND  (s)
        ) u_stage (
            .clk         (clk),
            .reset       (reset),
            .in_valid    (vld[s]),
            .in_ready    (rdy[s]),
            .in_data     (data[s]),
            .in_key      (key[s]),
            .in_decrypt  (dec[s]),
            .out_valid   (vld[s+1]),
            .out_ready   (rdy[s+1]),
            .out_data    (data[s+1]),
            .out_key     (key[s+1]),
            .out_decrypt (dec[s+1])
        );
    end

    assign in_ready  = rdy[0];
    assign out_valid = vld[STAGES];
    assign out_data  = data[STAGES];

    logic unused_tail;
    assign unused_tail = ^{key[STAGES], dec[STAGES]};

`ifdef BLK_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            blk_cnt <= '0;
        end else if (out_valid && out_ready) begin
            blk_cnt <= blk_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_byte_perm_pipe.sv
// Directed vector bench for byte_perm_pipe (LANES=4, WIDTH=8, STAGES=2).
module tb_byte_perm_pipe;

    localparam int LANES  = 4;
    localparam int WIDTH  = 8;
    localparam int STAGES = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [3:0]  in_key;
    logic        in_decrypt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
`ifdef BLK_CNT_EN
    logic [15:0] blk_cnt;
`endif

    int          n_vec = 0;
    int          n_err = 0;
    int          n_rx  = 0;
    logic        mon_en = 1'b0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] data;
        logic [3:0]  key;
        logic        dec;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    byte_perm_pipe #(.LANES(LANES), .WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_key     (in_key),
        .in_decrypt (in_decrypt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
`ifdef BLK_CNT_EN
        ,
        .blk_cnt    (blk_cnt)
`endif
    );

    // Reference: output lane j takes input lane src[sel][j].
    function automatic logic [31:0] ref_perm(input logic [31:0] d, input logic [3:0] k,
                                             input logic dec);
        int src [4][4];
        logic [7:0] a [4];
        logic [7:0] b [4];
        logic [31:0] o;
        int sl;
        int sel;
        src = '{'{1, 0, 3, 2}, '{0, 2, 1, 3}, '{3, 1, 2, 0}, '{0, 3, 2, 1}};
        for (int j = 0; j < 4; j++) a[j] = d[8*j +: 8];
        for (int r = 0; r < 2; r++) begin
            sl  = dec ? (1 - r) : r;
            sel = int'(k[2*sl +: 2]);
            for (int j = 0; j < 4; j++) b[j] = a[src[sel][j]];
            a = b;
        end
        for (int j = 0; j < 4; j++) o[8*j +: 8] = a[j];
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive_beat(input int k);
        in_valid   = 1'b1;
        in_data    = 32'hA0B1C2D3 + 32'(k) * 32'h01010101;
        in_key     = 4'(k * 3 + 1);
        in_decrypt = 1'(k & 1);
    endtask

    task automatic wait_drain(input string name);
        int c = 0;
        while (exp_q.size() != 0 && c < 50) begin
            @(posedge clk); #1;
            c++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    always @(negedge clk) begin
        if (mon_en && !reset && out_valid && out_ready) begin
            n_rx++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL spurious_out: got beat %h, expected none", out_data);
            end else begin
                check("stream_out", out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int k;
        int cyc;
        int rx0;
        int stale;
        logic acc;
        logic [31:0] prev;

        vecs[0] = '{32'h44332211, 4'b0100, 1'b0, 32'h33114422};
        vecs[1] = '{32'h33114422, 4'b0100, 1'b1, 32'h44332211};
        vecs[2] = '{32'h44332211, 4'b0000, 1'b0, 32'h44332211};
        vecs[3] = '{32'h44332211, 4'b1110, 1'b0, 32'h22331144};
        vecs[4] = '{32'h22331144, 4'b1110, 1'b1, 32'h44332211};
        vecs[5] = '{32'hDDCCBBAA, 4'b1001, 1'b0, 32'hAABBCCDD};
        vecs[6] = '{32'h04030201, 4'b0111, 1'b0, 32'h02040301};
        vecs[7] = '{32'h04030201, 4'b0111, 1'b1, 32'h03020401};

        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_key = '0;
        in_decrypt = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", out_data, 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
`ifdef BLK_CNT_EN
        check("reset_blk_cnt", 32'(blk_cnt), 32'd0);
`endif

        // Single beats from the vector table: latency and value.
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = vecs[i].data;
            in_key = vecs[i].key; in_decrypt = vecs[i].dec;
            @(posedge clk); #1;
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 20) begin
                @(posedge clk); #1;
                lat++;
            end
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
            check($sformatf("vec%0d_data", i), out_data, vecs[i].exp);
            @(posedge clk); #1;
        end

        // Back-to-back stream with random key and mode.
        mon_en = 1'b1;
        rx0 = n_rx;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = $urandom;
            in_key = 4'($urandom); in_decrypt = 1'($urandom);
            check("stream_in_ready", 32'(in_ready), 32'd1);
            exp_q.push_back(ref_perm(in_data, in_key, in_decrypt));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_drain("stream_drain");
        check("stream_count", 32'(n_rx - rx0), 32'd8);

        // Backpressure: five stalled cycles under continuous input.
        out_ready = 1'b0;
        k = 0;
        prev = '0;
        for (int c = 0; c < 5; c++) begin
            drive_beat(k);
            @(negedge clk);
            acc = in_ready;
            if (c >= 3) check("bp_hold_data", out_data, prev);
            prev = out_data;
            @(posedge clk); #1;
            if (acc) begin
                exp_q.push_back(ref_perm(in_data, in_key, in_decrypt));
                k++;
            end
        end
        check("bp_accepted", 32'(k), 32'd2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        cyc = 0;
        while (k < 6 && cyc < 50) begin
            drive_beat(k);
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) begin
                exp_q.push_back(ref_perm(in_data, in_key, in_decrypt));
                k++;
            end
            cyc++;
        end
        check("bp_release_accepted", 32'(k), 32'd6);
        in_valid = 1'b0;
        wait_drain("bp_drain");

        // Reset with two beats in flight.
        out_ready = 1'b0;
        drive_beat(10);
        @(posedge clk); #1;
        drive_beat(11);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("rst_pre_full", 32'(out_valid), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef BLK_CNT_EN
        check("rst_blk_cnt", 32'(blk_cnt), 32'd0);
`endif
        out_ready = 1'b1;
        stale = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("rst_no_stale", 32'(stale), 32'd0);
        @(posedge clk); #1;

`ifdef BLK_CNT_EN
        mon_en = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            in_data = 32'(i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("blk_cnt_wrap", 32'(blk_cnt), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
